regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Owns the single write port (address, data, write-enable) of the 32x32 integer register file.
- After reset, sweeps every register to zero.
- Then arbitrates the write port between two requesters:
  - the pipeline writeback stage, which has fixed priority;
  - a multi-cycle unit (divider/load-miss return), using a valid/ready handshake.
- Sits between writeback/multi-cycle logic and the register file; drives its write address, write data and write enable.

Parameters:
- NREGS, 32, number of architectural registers swept at init
- AW, 5, register address width
- DW, 32, data width
- MAX_WAIT, 4, cycles the multi-cycle requester may be refused before forced grant (only with optional feature)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- wb_we  in  1  writeback write request (single-cycle, no handshake)
- wb_addr  in  AW  writeback destination register
- wb_data  in  DW  writeback data
- wb_stall  out  1  pipeline must hold writeback stage and inputs
- mc_valid  in  1  multi-cycle result valid
- mc_addr  in  AW  multi-cycle destination register
- mc_data  in  DW  multi-cycle data
- mc_ready  out  1  multi-cycle result accepted this cycle when mc_valid=1
- rf_we  out  1  register-file write enable
- rf_addr  out  AW  register-file write address
- rf_wd  out  DW  register-file write data
- init_done  out  1  high once the clear sweep has completed

Behaviour:
- State: 2-state FSM ST_CLEAR/ST_RUN, clr_cnt[AW-1:0], wait_cnt (feature only). Outputs are combinational from state and inputs; zero added write latency (the register file samples on the same edge).
- Reset:
  - While rst=1 at an edge: state<=ST_CLEAR, clr_cnt<=0, wait_cnt<=0.
  - During a reset cycle: rf_we=0, rf_addr=0, rf_wd=0, wb_stall=1, mc_ready=0, init_done=0.
- ST_CLEAR (first cycle after rst deasserts):
  - rf_we=1, rf_addr=clr_cnt, rf_wd=0; clr_cnt increments each cycle.
  - wb_stall=1, mc_ready=0, init_done=0.
  - When clr_cnt==NREGS-1: state<=ST_RUN next edge.
  - Sweep is exactly NREGS cycles; clr_cnt never wraps.
- Reset asserted mid-sweep: sweep restarts from register 0.
- ST_RUN:
  - init_done=1.
  - Writeback wins when wb_we=1 and wb_addr!=0: rf_we=1, rf_addr=wb_addr, rf_wd=wb_data, mc_ready=0.
  - Otherwise mc_ready=1. If mc_valid=1 and mc_addr!=0: rf_we=1, rf_addr=mc_addr, rf_wd=mc_data.
  - x0 rule: a request to register 0 never asserts rf_we. A writeback to x0 leaves the port free. A multi-cycle request to x0 still completes its handshake (mc_ready=1), so the result is discarded.
  - Without the optional feature, wb_stall=0 in ST_RUN.
  - Idle (no request): rf_we=0, rf_addr=0, rf_wd=0.
- Handshake rules:
  - mc_valid, mc_addr and mc_data must hold stable until mc_valid&&mc_ready.
  - mc_ready may be high with mc_valid low; no transfer occurs.
- Same-address collision (wb_addr==mc_addr, both requesting): writeback writes; multi-cycle result is refused and retried next cycle. The later multi-cycle write therefore overwrites. Hazard ordering is the pipeline's responsibility.

Optional Feature:
- Macro RF_ARB_STARVE_GUARD_EN.
- Defined:
  - wait_cnt increments each ST_RUN cycle with mc_valid=1 and mc_ready=0.
  - wait_cnt clears on handshake or rst.
  - When wait_cnt==MAX_WAIT: mc_ready=1, multi-cycle unit writes, wb_stall=1, writeback is not written and must be re-presented next cycle.
  - wait_cnt saturates at MAX_WAIT.
- Not defined: no wait_cnt; the multi-cycle unit may starve indefinitely; wb_stall=0 throughout ST_RUN.

Decomposition:
- Package rf_arb_pkg holds:
  - state typedef (ST_CLEAR, ST_RUN);
  - constants REG_AW=5, REG_DW=32, REG_X0=0.
- One sub-module is natural: rf_clear_seq (clr_cnt, sweep address, done flag). The arbiter mux and FSM stay in the top module.

Test Plan:
- Release rst at cycle 0 -> rf_we=1 for exactly 32 cycles with rf_addr 0..31 and rf_wd=0. init_done rises on cycle 32; wb_stall=1 and mc_ready=0 throughout the sweep.
- Reset mid-sweep: pulse rst at sweep address 10 -> next sweep starts at rf_addr=0 and still takes 32 cycles.
- ST_RUN, wb_we=1 wb_addr=5 wb_data=0xDEADBEEF together with mc_valid=1 mc_addr=5 mc_data=0x1234:
  - cycle 1: rf_addr=5, rf_wd=0xDEADBEEF, mc_ready=0;
  - next cycle (wb_we=0): rf_wd=0x1234, mc_ready=1.
- wb_we=1 wb_addr=0 with mc_valid=1 mc_addr=7 mc_data=0xA5 -> rf_addr=7, rf_wd=0xA5, mc_ready=1. A separate mc request to x0 -> mc_ready=1, rf_we=0.
- With RF_ARB_STARVE_GUARD_EN, MAX_WAIT=4: continuous wb_we=1 wb_addr=3, mc_valid=1 mc_addr=9:
  - 4 refused cycles;
  - 5th cycle: mc_ready=1, rf_addr=9, wb_stall=1.
- Same stimulus without the macro -> mc_ready stays 0 and wb_stall stays 0 for 20+ cycles.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the FSM state encoding and the integer register-file geometry.
package rf_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_X0 = 0;

    // True when the address names the hard-wired zero register.
    function automatic logic is_x0(input logic [REG_AW-1:0] addr);
        return (addr == REG_AW'(REG_X0));
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle: writeback request, multi-cycle valid/ready channel and the
// register-file write port. master = arbiter side, slave = requester/regfile side.
interface regfile_wport_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
);

    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_stall;

    logic          mc_valid;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready;

    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wd;
    logic          init_done;

    modport master (
        input  wb_we, wb_addr, wb_data,
        input  mc_valid, mc_addr, mc_data,
        output wb_stall, mc_ready,
        output rf_we, rf_addr, rf_wd, init_done
    );

    modport slave (
        output wb_we, wb_addr, wb_data,
        output mc_valid, mc_addr, mc_data,
        input  wb_stall, mc_ready,
        input  rf_we, rf_addr, rf_wd, init_done
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sweep counter: walks addresses 0..NREGS-1 once and flags
// the final address. Holds at the last address rather than wrapping.
module rf_clear_seq
    import rf_arb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    logic [AW-1:0] clr_cnt_reg;
    logic [AW-1:0] clr_cnt_next;

    always_comb begin
        clr_cnt_next = clr_cnt_reg;
        if (en && !last) begin
            clr_cnt_next = clr_cnt_reg + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_reg <= '0;
        end else begin
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign addr = clr_cnt_reg;
    assign last = (clr_cnt_reg == LAST_ADDR);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port owner: clears x0..x31 after reset, then arbitrates
// writeback (fixed priority) against a multi-cycle valid/ready requester.
// Optional starvation guard: define RF_ARB_STARVE_GUARD_EN.
module regfile_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int AW       = REG_AW,
    parameter int DW       = REG_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_wport_arbiter_if.master bus
);

    state_t state_reg;
    state_t state_next;

    logic [AW-1:0] clr_addr;
    logic          clr_last;

    logic          wb_req;
    logic          mc_wr;
    logic          mc_force;

    logic          rf_we_c;
    logic [AW-1:0] rf_addr_c;
    logic [DW-1:0] rf_wd_c;
    logic          wb_stall_c;
    logic          mc_ready_c;
    logic          init_done_c;

    rf_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg == ST_CLEAR),
        .addr (clr_addr),
        .last (clr_last)
    );

    // Requests aimed at x0 never reach the register file.
    assign wb_req = bus.wb_we    && (bus.wb_addr != AW'(REG_X0));
    assign mc_wr  = bus.mc_valid && (bus.mc_addr != AW'(REG_X0));

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;

    assign mc_force = bus.mc_valid && (wait_cnt_reg == WAIT_LIMIT);

    // Count refused cycles of a pending multi-cycle result; any handshake clears.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if ((state_reg == ST_RUN) && bus.mc_valid) begin
            if (mc_ready_c) begin
                wait_cnt_next = '0;
            end else if (wait_cnt_reg != WAIT_LIMIT) begin
                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    // Guard disabled: writeback always wins, whatever MAX_WAIT says.
    assign mc_force = 1'b0 && (MAX_WAIT > 0);
`endif

    always_comb begin
        state_next  = state_reg;
        rf_we_c     = 1'b0;
        rf_addr_c   = '0;
        rf_wd_c     = '0;
        wb_stall_c  = 1'b1;
        mc_ready_c  = 1'b0;
        init_done_c = 1'b0;

        // Outputs stay quiet for the whole reset cycle, whatever the state.
        if (!rst) begin
            case (state_reg)
                ST_CLEAR: begin
                    rf_we_c   = 1'b1;
                    rf_addr_c = clr_addr;
                    if (clr_last) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done_c = 1'b1;
                    wb_stall_c  = 1'b0;
                    if (mc_force) begin
                        wb_stall_c = 1'b1;
                        mc_ready_c = 1'b1;
                        if (mc_wr) begin
                            rf_we_c   = 1'b1;
                            rf_addr_c = bus.mc_addr;
                            rf_wd_c   = bus.mc_data;
                        end
                    end else if (wb_req) begin
                        rf_we_c   = 1'b1;
                        rf_addr_c = bus.wb_addr;
                        rf_wd_c   = bus.wb_data;
                    end else begin
                        // Port free: accept (or discard, for x0) any multi-cycle result.
                        mc_ready_c = 1'b1;
                        if (mc_wr) begin
                            rf_we_c   = 1'b1;
                            rf_addr_c = bus.mc_addr;
                            rf_wd_c   = bus.mc_data;
                        end
                    end
                end
                default: begin
                    state_next = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.rf_we     = rf_we_c;
    assign bus.rf_addr   = rf_addr_c;
    assign bus.rf_wd     = rf_wd_c;
    assign bus.wb_stall  = wb_stall_c;
    assign bus.mc_ready  = mc_ready_c;
    assign bus.init_done = init_done_c;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_regfile_wport_arbiter;

    localparam int NREGS    = 32;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wport_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_wport_arbiter #(
        .NREGS    (NREGS),
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed view: {rf_we, rf_addr, rf_wd, wb_stall, mc_ready, init_done}
    logic [40:0] obs;
    assign obs = {bus.rf_we, bus.rf_addr, bus.rf_wd, bus.wb_stall, bus.mc_ready, bus.init_done};

    function automatic logic [40:0] pack(input logic we, input logic [4:0] a, input logic [31:0] d,
                                         input logic st, input logic rd, input logic dn);
        return {we, a, d, st, rd, dn};
    endfunction

    // Reference model: cycles since reset release decide clear vs run; in run the
    // priority rules of the write port are applied directly.
    function automatic logic [40:0] model(input logic r, input int cyc, input int wt,
                                          input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                                          input logic mv, input logic [4:0] ma, input logic [31:0] md);
        if (r) return pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        if (cyc < NREGS) return pack(1'b1, 5'(cyc), 32'd0, 1'b1, 1'b0, 1'b0);
        if (GUARD && mv && wt >= MAX_WAIT) begin
            if (ma != 5'd0) return pack(1'b1, ma, md, 1'b1, 1'b1, 1'b1);
            return pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        end
        if (wbwe && wba != 5'd0) return pack(1'b1, wba, wbd, 1'b0, 1'b0, 1'b1);
        if (mv && ma != 5'd0) return pack(1'b1, ma, md, 1'b0, 1'b1, 1'b1);
        return pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    endfunction

    int          m_cyc  = 0;
    int          m_wait = 0;
    logic [40:0] m_prev = '0;

    always @(posedge clk) begin : model_step
        logic [40:0] e;
        e = model(rst, m_cyc, m_wait, bus.wb_we, bus.wb_addr, bus.wb_data,
                  bus.mc_valid, bus.mc_addr, bus.mc_data);
        m_prev <= e;
        if (rst) begin
            m_cyc  <= 0;
            m_wait <= 0;
        end else begin
            if (m_cyc < NREGS) m_cyc <= m_cyc + 1;
            if (m_cyc >= NREGS && bus.mc_valid) begin
                if (e[1]) m_wait <= 0;
                else if (m_wait < MAX_WAIT) m_wait <= m_wait + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.mc_valid = 1'b0;
        bus.mc_addr  = '0;
        bus.mc_data  = '0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd4;
        bus.wb_data  = $urandom;
        bus.mc_valid = 1'b1;
        bus.mc_addr  = 5'd6;
        bus.mc_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, obs,
                         pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        idle_inputs();
        $display("test_reset: 3 reset cycles checked");
    endtask

    task automatic test_sweep();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL sweep addr %0d: got %h expected %h", i, obs,
                         pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL sweep_done idle: got %h expected %h", obs,
                     pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1));
        end
        tick();
        $display("test_sweep: %0d clear writes then init_done", NREGS);
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL partial_sweep addr %0d: got %h expected %h", i, obs,
                         pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_sweep_reset: got %h expected %h", obs,
                     pack(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0));
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL restart_sweep addr %0d: got %h expected %h", i, obs,
                         pack(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL restart_done idle: got %h expected %h", obs,
                     pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1));
        end
        tick();
        $display("test_reset_mid_sweep: restarted from x0 after reset at addr 11");
    endtask

    task automatic test_collision();
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        bus.mc_valid = 1'b1;
        bus.mc_addr  = 5'd5;
        bus.mc_data  = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL collision_wb_wins: got %h expected %h", obs,
                     pack(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
        end
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL collision_mc_retry: got %h expected %h", obs,
                     pack(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1, 1'b1));
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL collision_idle: got %h expected %h", obs,
                     pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1));
        end
        tick();
        $display("test_collision: wb x5 then mc x5 retried");
    endtask

    task automatic test_x0();
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = $urandom;
        bus.mc_valid = 1'b1;
        bus.mc_addr  = 5'd7;
        bus.mc_data  = 32'h0000_00A5;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd7, 32'h0000_00A5, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL wb_x0_frees_port: got %h expected %h", obs,
                     pack(1'b1, 5'd7, 32'h0000_00A5, 1'b0, 1'b1, 1'b1));
        end
        tick();
        bus.wb_we   = 1'b0;
        bus.mc_addr = 5'd0;
        bus.mc_data = 32'h5555_5555;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL mc_x0_discard: got %h expected %h", obs,
                     pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1));
        end
        tick();
        idle_inputs();
        $display("test_x0: x0 requests never write");
    endtask

    task automatic test_starve();
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'h3333_3333;
        bus.mc_valid = 1'b1;
        bus.mc_addr  = 5'd9;
        bus.mc_data  = 32'h0000_0099;
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL starve_refused cycle %0d: got %h expected %h", i, obs,
                         pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL starve_forced_grant: got %h expected %h", obs,
                     pack(1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1, 1'b1));
        end
        tick();
        bus.mc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL starve_wb_represent: got %h expected %h", obs,
                     pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1));
        end
        tick();
`else
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL starve_unguarded cycle %0d: got %h expected %h", i, obs,
                         pack(1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b1));
            end
            tick();
        end
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b1, 5'd9, 32'h0000_0099, 1'b0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL starve_release: got %h expected %h", obs,
                     pack(1'b1, 5'd9, 32'h0000_0099, 1'b0, 1'b1, 1'b1));
        end
        tick();
`endif
        idle_inputs();
        $display("test_starve: guard=%0d", GUARD);
    endtask

    task automatic test_random();
        logic [40:0] e;
        int          xfers = 0;
        for (int i = 0; i < 400; i++) begin
            // Hold a multi-cycle request until accepted; re-present a stalled writeback.
            if (!(bus.mc_valid && !m_prev[1])) begin
                bus.mc_valid = ($urandom_range(0, 2) != 0);
                bus.mc_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.mc_data  = $urandom;
            end
            if (!(bus.wb_we && m_prev[2] && m_prev[0])) begin
                bus.wb_we   = ($urandom_range(0, 9) < 6);
                bus.wb_addr = 5'($urandom_range(0, 31));
                bus.wb_data = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            e = model(rst, m_cyc, m_wait, bus.wb_we, bus.wb_addr, bus.wb_data,
                      bus.mc_valid, bus.mc_addr, bus.mc_data);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, e);
            end
            if (e[1] && bus.mc_valid) begin
                xfers++;
                $display("mc xfer %0d: x%0d <= %h", xfers, bus.mc_addr, bus.mc_data);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sweep();
        test_reset_mid_sweep();
        test_collision();
        test_x0();
        test_starve();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
